// File: rtl/pc_sequencer_if.sv
// Fetch-address handshake between the PC sequencer and instruction memory.
// The sequencer presents oPC/oFetchValid; memory answers with iFetchReady.
interface pc_sequencer_if;
    logic [31:0] oPC;
    logic        oFetchValid;
    logic        iFetchReady;

    modport master (
        output oPC,
        output oFetchValid,
        input  iFetchReady
    );

    modport slave (
        input  oPC,
        input  oFetchValid,
        output iFetchReady
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage PC controller: redirect arbitration, stall-pending merge,
// return-address stack and flush pulse generation.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          RAS_DEPTH = 4
) (
    input  logic                  iClk,
    input  logic                  iReset,
    input  logic                  iStall,
    input  logic                  iMissReq,
    input  logic [31:0]           iMissAddr,
    input  logic                  iJumpReq,
    input  logic                  iCallReq,
    input  logic [25:0]           iJumpOffset,
    input  logic                  iRetReq,
    input  logic                  iBranchReq,
    input  logic [31:0]           iBranchAddr,
    pc_sequencer_if.master        fetch,
    output logic                  oFlush,
    output logic                  oRasEmpty,
    output logic                  oRasUnderflow
);

    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    // Encoding order doubles as the priority order.
    typedef enum logic [2:0] {
        REQ_NONE = 3'd0,
        REQ_BR   = 3'd1,
        REQ_RET  = 3'd2,
        REQ_JMP  = 3'd3,
        REQ_CALL = 3'd4,
        REQ_MISS = 3'd5
    } req_e;

    logic [31:0]   pc_q, pc_d;
    req_e          pend_kind_q, pend_kind_d;
    logic [31:0]   pend_arg_q, pend_arg_d;
    logic [PW-1:0] top_q, top_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          flush_q, flush_d;
    logic          unf_q, unf_d;
    logic [31:0]   ras_mem [RAS_DEPTH];

    req_e          in_kind, eff_kind;
    logic [31:0]   in_arg, eff_arg;
    logic [31:0]   next_seq, jump_tgt;
    logic          push;

    assign next_seq = pc_q + 32'd4;
    assign jump_tgt = {next_seq[31:26], eff_arg[25:0]};

    always_comb begin
        in_kind = REQ_NONE;
        in_arg  = '0;
        priority case (1'b1)
            iMissReq:   begin in_kind = REQ_MISS; in_arg = iMissAddr; end
            iCallReq:   begin in_kind = REQ_CALL; in_arg = {6'd0, iJumpOffset}; end
            iJumpReq:   begin in_kind = REQ_JMP;  in_arg = {6'd0, iJumpOffset}; end
            iRetReq:    begin in_kind = REQ_RET;  in_arg = '0; end
            iBranchReq: begin in_kind = REQ_BR;   in_arg = iBranchAddr; end
            default:    begin in_kind = REQ_NONE; in_arg = '0; end
        endcase
    end

    // Incoming wins ties against the held request.
    always_comb begin
        eff_kind = pend_kind_q;
        eff_arg  = pend_arg_q;
        if (in_kind >= pend_kind_q) begin
            eff_kind = in_kind;
            eff_arg  = in_arg;
        end
    end

    always_comb begin
        pc_d        = pc_q;
        pend_kind_d = pend_kind_q;
        pend_arg_d  = pend_arg_q;
        top_d       = top_q;
        cnt_d       = cnt_q;
        flush_d     = 1'b0;
        unf_d       = 1'b0;
        push        = 1'b0;
        if (iStall) begin
            if (in_kind != REQ_NONE && in_kind >= pend_kind_q) begin
                pend_kind_d = in_kind;
                pend_arg_d  = in_arg;
            end
        end else begin
            pend_kind_d = REQ_NONE;
            pend_arg_d  = '0;
            flush_d     = (eff_kind != REQ_NONE);
            unique case (eff_kind)
                REQ_MISS: pc_d = eff_arg;
                REQ_CALL: begin
                    pc_d = jump_tgt;
                    push = 1'b1;
                end
                REQ_JMP:  pc_d = jump_tgt;
                REQ_RET: begin
                    if (cnt_q != '0) begin
                        pc_d  = ras_mem[top_q];
                        top_d = top_q - 1'b1;
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        pc_d  = next_seq;
                        unf_d = 1'b1;
                    end
                end
                REQ_BR:   pc_d = eff_arg;
                default: begin
                    if (fetch.iFetchReady) pc_d = next_seq;
                end
            endcase
            // A full stack overwrites its oldest slot as the pointer wraps.
            if (push) begin
                top_d = top_q + 1'b1;
                if (cnt_q != CW'(RAS_DEPTH)) cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            pc_q        <= RESET_PC;
            pend_kind_q <= REQ_NONE;
            pend_arg_q  <= '0;
            top_q       <= '0;
            cnt_q       <= '0;
            flush_q     <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            pend_kind_q <= pend_kind_d;
            pend_arg_q  <= pend_arg_d;
            top_q       <= top_d;
            cnt_q       <= cnt_d;
            flush_q     <= flush_d;
            unf_q       <= unf_d;
        end
    end

    always_ff @(posedge iClk) begin
        if (push && !iReset) ras_mem[top_d] <= next_seq;
    end

    assign fetch.oPC         = pc_q;
    assign fetch.oFetchValid = !iStall && !iReset;
    assign oFlush            = flush_q;
    assign oRasUnderflow     = unf_q;
    assign oRasEmpty         = (cnt_q == '0);

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: each scenario queues expected
// PC/flag results per cycle and compares them after the clock edge.
module tb_pc_sequencer;

    typedef struct {
        bit          st, rd, ms, cl, jp, rt, br;
        logic [31:0] ma, ba;
        logic [25:0] off;
    } stim_t;

    typedef struct {
        logic [31:0] pc;
        logic        fl, em, uf;
    } exp_t;

    logic        iClk = 1'b0;
    logic        iReset = 1'b1;
    logic        iStall = 1'b0;
    logic        iMissReq = 1'b0;
    logic [31:0] iMissAddr = '0;
    logic        iJumpReq = 1'b0;
    logic        iCallReq = 1'b0;
    logic [25:0] iJumpOffset = '0;
    logic        iRetReq = 1'b0;
    logic        iBranchReq = 1'b0;
    logic [31:0] iBranchAddr = '0;
    logic        oFlush, oRasEmpty, oRasUnderflow;

    int tests = 0;
    int failed = 0;
    exp_t sb[$];

    pc_sequencer_if fif ();

    pc_sequencer #(.RESET_PC(32'h0), .RAS_DEPTH(4)) dut (
        .iClk(iClk),
        .iReset(iReset),
        .iStall(iStall),
        .iMissReq(iMissReq),
        .iMissAddr(iMissAddr),
        .iJumpReq(iJumpReq),
        .iCallReq(iCallReq),
        .iJumpOffset(iJumpOffset),
        .iRetReq(iRetReq),
        .iBranchReq(iBranchReq),
        .iBranchAddr(iBranchAddr),
        .fetch(fif.master),
        .oFlush(oFlush),
        .oRasEmpty(oRasEmpty),
        .oRasUnderflow(oRasUnderflow)
    );

    always #5 iClk = ~iClk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic stim_t mk(input bit st, rd, ms, input logic [31:0] ma,
                                 input bit cl, jp, input logic [25:0] off,
                                 input bit rt, br, input logic [31:0] ba);
        stim_t s;
        s.st = st; s.rd = rd; s.ms = ms; s.ma = ma; s.cl = cl;
        s.jp = jp; s.off = off; s.rt = rt; s.br = br; s.ba = ba;
        return s;
    endfunction

    function automatic stim_t idle(input bit rd);
        return mk(0, rd, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic exp_t ex(input logic [31:0] pc, input logic fl, em, uf);
        exp_t e;
        e.pc = pc; e.fl = fl; e.em = em; e.uf = uf;
        return e;
    endfunction

    task automatic apply(input stim_t s);
        iStall = s.st; fif.iFetchReady = s.rd;
        iMissReq = s.ms; iMissAddr = s.ma;
        iCallReq = s.cl; iJumpReq = s.jp; iJumpOffset = s.off;
        iRetReq = s.rt; iBranchReq = s.br; iBranchAddr = s.ba;
    endtask

    task automatic test_reset();
        stim_t s[$];
        exp_t e;
        fif.iFetchReady = 1'b0;
        #1;
        tests++;
        if ({fif.oPC, fif.oFetchValid, oFlush, oRasEmpty, oRasUnderflow} !==
            {32'h0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            failed++;
            $display("FAIL reset_state got pc=%h fv/fl/em/uf=%b%b%b%b exp pc=0 0010",
                     fif.oPC, fif.oFetchValid, oFlush, oRasEmpty, oRasUnderflow);
        end
        repeat (2) @(posedge iClk);
        #1;
        iReset = 1'b0;
        apply(idle(1));
        #1;
        tests++;
        if ({fif.oPC, fif.oFetchValid} !== {32'h0, 1'b1}) begin
            failed++;
            $display("FAIL reset_release got pc=%h fv=%b exp pc=0 fv=1",
                     fif.oPC, fif.oFetchValid);
        end
        for (int k = 1; k <= 3; k++) begin
            s.push_back(idle(1));
            sb.push_back(ex(32'(4 * k), 0, 1, 0));
        end
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            @(posedge iClk);
            #1;
            e = sb.pop_front();
            tests++;
            if ({fif.oPC, oFlush, oRasEmpty, oRasUnderflow, fif.oFetchValid} !==
                {e.pc, e.fl, e.em, e.uf, ~s[i].st}) begin
                failed++;
                $display("FAIL seq[%0d] got pc=%h fl/em/uf/fv=%b%b%b%b exp pc=%h %b%b%b%b",
                         i, fif.oPC, oFlush, oRasEmpty, oRasUnderflow, fif.oFetchValid,
                         e.pc, e.fl, e.em, e.uf, ~s[i].st);
            end
        end
    endtask

    task automatic test_call_ret();
        stim_t s[$];
        exp_t e;
        s.push_back(mk(0, 0, 1, 32'h0040_0010, 0, 0, 0, 0, 0, 0));
        sb.push_back(ex(32'h0040_0010, 1, 1, 0));
        s.push_back(mk(0, 0, 0, 0, 1, 0, 26'h100, 0, 0, 0));
        sb.push_back(ex(32'h0000_0100, 1, 0, 0));
        s.push_back(idle(0));
        sb.push_back(ex(32'h0000_0100, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        sb.push_back(ex(32'h0040_0014, 1, 1, 0));
        s.push_back(idle(0));
        sb.push_back(ex(32'h0040_0014, 0, 1, 0));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            @(posedge iClk);
            #1;
            e = sb.pop_front();
            tests++;
            if ({fif.oPC, oFlush, oRasEmpty, oRasUnderflow, fif.oFetchValid} !==
                {e.pc, e.fl, e.em, e.uf, ~s[i].st}) begin
                failed++;
                $display("FAIL call_ret[%0d] got pc=%h fl/em/uf/fv=%b%b%b%b exp pc=%h %b%b%b%b",
                         i, fif.oPC, oFlush, oRasEmpty, oRasUnderflow, fif.oFetchValid,
                         e.pc, e.fl, e.em, e.uf, ~s[i].st);
            end
        end
    endtask

    task automatic test_priority();
        stim_t s[$];
        exp_t e;
        s.push_back(mk(0, 0, 0, 0, 1, 0, 26'h40, 0, 0, 0));
        sb.push_back(ex(32'h0000_0040, 1, 0, 0));
        s.push_back(mk(0, 0, 1, 32'h2000, 0, 0, 0, 1, 1, 32'h3000));
        sb.push_back(ex(32'h0000_2000, 1, 0, 0));
        s.push_back(idle(0));
        sb.push_back(ex(32'h0000_2000, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        sb.push_back(ex(32'h0040_0018, 1, 1, 0));
        s.push_back(idle(0));
        sb.push_back(ex(32'h0040_0018, 0, 1, 0));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            @(posedge iClk);
            #1;
            e = sb.pop_front();
            tests++;
            if ({fif.oPC, oFlush, oRasEmpty, oRasUnderflow, fif.oFetchValid} !==
                {e.pc, e.fl, e.em, e.uf, ~s[i].st}) begin
                failed++;
                $display("FAIL priority[%0d] got pc=%h fl/em/uf/fv=%b%b%b%b exp pc=%h %b%b%b%b",
                         i, fif.oPC, oFlush, oRasEmpty, oRasUnderflow, fif.oFetchValid,
                         e.pc, e.fl, e.em, e.uf, ~s[i].st);
            end
        end
    endtask

    task automatic test_stall();
        stim_t s[$];
        exp_t e;
        s.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 32'h500));
        sb.push_back(ex(32'h0040_0018, 0, 1, 0));
        s.push_back(mk(1, 1, 0, 0, 0, 1, 26'hABC, 0, 0, 0));
        sb.push_back(ex(32'h0040_0018, 0, 1, 0));
        s.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(ex(32'h0040_0018, 0, 1, 0));
        s.push_back(idle(1));
        sb.push_back(ex(32'h0000_0ABC, 1, 1, 0));
        s.push_back(idle(1));
        sb.push_back(ex(32'h0000_0AC0, 0, 1, 0));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            @(posedge iClk);
            #1;
            e = sb.pop_front();
            tests++;
            if ({fif.oPC, oFlush, oRasEmpty, oRasUnderflow, fif.oFetchValid} !==
                {e.pc, e.fl, e.em, e.uf, ~s[i].st}) begin
                failed++;
                $display("FAIL stall[%0d] got pc=%h fl/em/uf/fv=%b%b%b%b exp pc=%h %b%b%b%b",
                         i, fif.oPC, oFlush, oRasEmpty, oRasUnderflow, fif.oFetchValid,
                         e.pc, e.fl, e.em, e.uf, ~s[i].st);
            end
        end
    endtask

    task automatic test_ras_overflow();
        stim_t s[$];
        exp_t e;
        for (int k = 1; k <= 5; k++) begin
            s.push_back(mk(0, 0, 1, 32'(16 * k), 0, 0, 0, 0, 0, 0));
            sb.push_back(ex(32'(16 * k), 1, (k == 1), 0));
            s.push_back(mk(0, 0, 0, 0, 1, 0, 26'h1000, 0, 0, 0));
            sb.push_back(ex(32'h0000_1000, 1, 0, 0));
        end
        for (int k = 0; k < 4; k++) begin
            s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
            sb.push_back(ex(32'h54 - 32'(16 * k), 1, (k == 3), 0));
        end
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        sb.push_back(ex(32'h28, 1, 1, 1));
        s.push_back(idle(0));
        sb.push_back(ex(32'h28, 0, 1, 0));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            @(posedge iClk);
            #1;
            e = sb.pop_front();
            tests++;
            if ({fif.oPC, oFlush, oRasEmpty, oRasUnderflow, fif.oFetchValid} !==
                {e.pc, e.fl, e.em, e.uf, ~s[i].st}) begin
                failed++;
                $display("FAIL ras[%0d] got pc=%h fl/em/uf/fv=%b%b%b%b exp pc=%h %b%b%b%b",
                         i, fif.oPC, oFlush, oRasEmpty, oRasUnderflow, fif.oFetchValid,
                         e.pc, e.fl, e.em, e.uf, ~s[i].st);
            end
        end
    endtask

    task automatic test_wrap_back_to_back();
        stim_t s[$];
        exp_t e;
        s.push_back(mk(0, 1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0));
        sb.push_back(ex(32'hFFFF_FFFC, 1, 1, 0));
        s.push_back(idle(1));
        sb.push_back(ex(32'h0000_0000, 0, 1, 0));
        s.push_back(idle(1));
        sb.push_back(ex(32'h0000_0004, 0, 1, 0));
        for (int k = 1; k <= 3; k++) begin
            s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'(256 * k)));
            sb.push_back(ex(32'(256 * k), 1, 1, 0));
        end
        s.push_back(idle(0));
        sb.push_back(ex(32'h300, 0, 1, 0));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            @(posedge iClk);
            #1;
            e = sb.pop_front();
            tests++;
            if ({fif.oPC, oFlush, oRasEmpty, oRasUnderflow, fif.oFetchValid} !==
                {e.pc, e.fl, e.em, e.uf, ~s[i].st}) begin
                failed++;
                $display("FAIL wrap_b2b[%0d] got pc=%h fl/em/uf/fv=%b%b%b%b exp pc=%h %b%b%b%b",
                         i, fif.oPC, oFlush, oRasEmpty, oRasUnderflow, fif.oFetchValid,
                         e.pc, e.fl, e.em, e.uf, ~s[i].st);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        stim_t s[$];
        exp_t e;
        s.push_back(mk(0, 0, 1, 32'h900, 0, 0, 0, 0, 0, 0));
        sb.push_back(ex(32'h900, 1, 1, 0));
        s.push_back(mk(1, 0, 1, 32'h7777, 0, 0, 0, 0, 0, 0));
        sb.push_back(ex(32'h900, 0, 1, 0));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            @(posedge iClk);
            #1;
            e = sb.pop_front();
            tests++;
            if ({fif.oPC, oFlush, oRasEmpty, oRasUnderflow, fif.oFetchValid} !==
                {e.pc, e.fl, e.em, e.uf, ~s[i].st}) begin
                failed++;
                $display("FAIL rst_stall[%0d] got pc=%h fl/em/uf/fv=%b%b%b%b exp pc=%h %b%b%b%b",
                         i, fif.oPC, oFlush, oRasEmpty, oRasUnderflow, fif.oFetchValid,
                         e.pc, e.fl, e.em, e.uf, ~s[i].st);
            end
        end
        apply(idle(0));
        #2;
        iReset = 1'b1;
        #1;
        tests++;
        if ({fif.oPC, fif.oFetchValid} !== {32'h0, 1'b0}) begin
            failed++;
            $display("FAIL rst_async got pc=%h fv=%b exp pc=0 fv=0",
                     fif.oPC, fif.oFetchValid);
        end
        @(posedge iClk);
        #1;
        iReset = 1'b0;
        sb.push_back(ex(32'h0, 0, 1, 0));
        @(posedge iClk);
        #1;
        e = sb.pop_front();
        tests++;
        if ({fif.oPC, oFlush, oRasEmpty, oRasUnderflow} !==
            {e.pc, e.fl, e.em, e.uf}) begin
            failed++;
            $display("FAIL rst_discard got pc=%h fl/em/uf=%b%b%b exp pc=%h %b%b%b",
                     fif.oPC, oFlush, oRasEmpty, oRasUnderflow, e.pc, e.fl, e.em, e.uf);
        end
    endtask

    initial begin
        test_reset();
        test_call_ret();
        test_priority();
        test_stall();
        test_ras_overflow();
        test_wrap_back_to_back();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter controller for the fetch stage. It owns the PC register and a small return-address stack (RAS), and arbitrates redirect requests (mispredict recovery, jump/call, return, taken branch) against sequential fetch. It holds requests that arrive during a pipeline stall and presents the fetch address to instruction memory with a valid/ready handshake. It replaces ad-hoc next-PC selection and issues the flush pulse to the front-end pipeline registers.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- RAS_DEPTH, 4, return-address stack entries (power of two, 2..16)

Ports:
- iClk  in  1  clock; all state updates on rising edge
- iReset  in  1  asynchronous, active-high reset
- iStall  in  1  pipeline stall; freezes PC and RAS
- iFetchReady  in  1  instruction memory accepts oPC this cycle
- iMissReq  in  1  branch-miss recovery request
- iMissAddr  in  32  recovery target
- iJumpReq  in  1  jump request
- iCallReq  in  1  jump-and-link request (jump + RAS push)
- iJumpOffset  in  26  jump/call target low bits
- iRetReq  in  1  return request (RAS pop)
- iBranchReq  in  1  taken-branch request
- iBranchAddr  in  32  branch target
- oPC  out  32  current fetch address
- oFetchValid  out  1  oPC valid for fetch
- oFlush  out  1  one-cycle pulse: squash wrong-path fetch/decode
- oRasEmpty  out  1  RAS holds no entries
- oRasUnderflow  out  1  one-cycle pulse: return popped an empty RAS

## Operation
- NextSeq = oPC + 4 (mod 2^32, wraps silently).
- Jump/call target = {NextSeq[31:26], iJumpOffset}.
- Request priority, highest first: miss > call > jump > return > branch. Only the winner acts; losers in the same cycle are dropped.
- Pending register: holds one request kind plus its operands (target/offset).
  - When iStall=1, the winning incoming request is merged into pending: it replaces pending only if its priority is greater than or equal to pending's.
  - Pending clears on application or on reset.
- When iStall=0, effective request = higher-priority of (incoming winner, pending). On a tie, incoming wins.
  - Miss: oPC <= iMissAddr. RAS untouched.
  - Call: push NextSeq; oPC <= jump target.
  - Jump: oPC <= jump target.
  - Return, RAS non-empty: pop; oPC <= popped entry.
  - Return, RAS empty: oPC <= NextSeq; pulse oRasUnderflow.
  - Branch: oPC <= iBranchAddr.
  - Any effective request sets oFlush=1 in the next cycle.
  - No request and iFetchReady=1: oPC <= NextSeq.
  - No request and iFetchReady=0: hold oPC.
- Redirects apply regardless of iFetchReady, because the unaccepted address is wrong-path.
- RAS: circular buffer with top pointer and saturating count (0..RAS_DEPTH).
  - Push when full overwrites the oldest entry; count stays RAS_DEPTH.
  - oRasEmpty = (count==0).
- oFetchValid = !iStall, forced to 0 while iReset is asserted.

## Timing
- Reset (async assert) values: oPC=RESET_PC, oFetchValid=0, oFlush=0, oRasUnderflow=0, oRasEmpty=1, pending cleared, RAS count=0.
- Reset deassertion: oFetchValid=1 in the first cycle with iStall=0.
- Redirect latency: request sampled at edge N with iStall=0 gives new oPC and oFlush=1 after edge N (a single cycle). oFlush drops after edge N+1 unless another redirect occurs.
- A request during a stall is applied on the first edge with iStall=0. oFlush is asserted the cycle after that edge.
- Reset mid-stall with a pending request discards the request. PC returns to RESET_PC.
- Back-to-back redirects on consecutive cycles are each applied. oFlush stays high.
- Sequential advance: 1 cycle per accepted fetch; zero bubbles when iFetchReady=1.

## Test plan
- Reset then iFetchReady=1 for 3 cycles -> oPC = 0x0, 0x4, 0x8, 0xC. oFetchValid=1, oFlush=0.
- oPC=0x00400010, iCallReq with offset 0x0000100 -> next oPC=0x00000100, oFlush=1 for one cycle. Then iRetReq -> oPC=0x00400014, oRasEmpty=1.
- iMissReq(0x2000) together with iBranchReq(0x3000) and iRetReq -> oPC=0x2000, RAS count unchanged, single oFlush pulse.
- iStall=1 for 3 cycles, iBranchReq(0x500) pulsed in the 1st stall cycle, iJumpReq in the 2nd -> oPC frozen during the stall. First unstalled edge gives jump target, not 0x500; one oFlush pulse.
- RAS_DEPTH=4: 5 calls from 0x10, 0x20, 0x30, 0x40, 0x50, then 5 returns -> returns to 0x54, 0x44, 0x34, 0x24, then 5th return yields that return's NextSeq with oRasUnderflow=1.
- oPC=0xFFFFFFFC, iFetchReady=1 -> oPC=0x00000000. Reset asserted mid-stall with a pending miss -> oPC=RESET_PC and the miss is never applied.
